sp_ram_sync_param: RTL



---
 rtl/sp_ram_pkg.sv | 17 +
 rtl/sp_ram_init_ctrl.sv | 61 ++++++
 rtl/sp_ram_sync_param.sv | 118 +++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// Shared constants and types for the parametrised single-port RAM and its clear controller.
package sp_ram_pkg;

  localparam int MODE_WRITE_FIRST = 0;
  localparam int MODE_READ_FIRST  = 1;
  localparam int MODE_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sp_ram_init_ctrl.sv
// Post-reset clear sequencer: walks every word writing zero, drives busy, and
// muxes either the clear write or the user write onto the array write port.
module sp_ram_init_ctrl import sp_ram_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  localparam int BE_W  = be_width(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] DI,
  output logic              busy,
  output logic              accept,
  output logic              in_range,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == LAST_ADDR) begin
        state <= ST_READY;
        busy  <= 1'b0;
      end
    end
  end

  assign in_range = ({1'b0, address} < DEPTH_L);
  assign accept   = en && (state == ST_READY) && !RST;

  // Out-of-range user writes are dropped here so the array never sees them.
  always_comb begin
    mem_addr  = address;
    mem_wdata = DI;
    mem_be    = '0;
    if (state == ST_CLEAR) begin
      mem_addr  = clr_addr;
      mem_wdata = '0;
      mem_be    = RST ? '0 : '1;
    end else if (accept && we && in_range) begin
      mem_be = be;
    end
  end

endmodule

// File: rtl/sp_ram_sync_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable read-during-write
// mode and post-reset clear. Define SP_RAM_OUT_REG_EN for an extra output register (latency 2).
module sp_ram_sync_param import sp_ram_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int MODE   = 0,
  localparam int BE_W  = be_width(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  output logic              rd_valid,
  output logic              busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] do_s1;
  logic              valid_s1;

  sp_ram_init_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .we        (we),
    .be        (be),
    .address   (address),
    .DI        (DI),
    .busy      (busy),
    .accept    (accept),
    .in_range  (in_range),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge CLK) begin
    for (int i = 0; i < BE_W; i++) begin
      if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  assign rd_word = in_range ? mem[address] : '0;

  // Word as it will look after this write; used for write-first readback.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = DI[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_s1    <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= 1'b0;
      if (accept) begin
        if (!we) begin
          do_s1    <= rd_word;
          valid_s1 <= 1'b1;
        end else begin
          case (MODE)
            MODE_READ_FIRST: begin
              do_s1    <= rd_word;
              valid_s1 <= 1'b1;
            end
            MODE_NO_CHANGE: ;
            default: begin
              do_s1    <= merged;
              valid_s1 <= 1'b1;
            end
          endcase
        end
      end
    end
  end

`ifdef SP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] do_s2;
  logic              valid_s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_s2    <= '0;
      valid_s2 <= 1'b0;
    end else begin
      valid_s2 <= valid_s1;
      if (valid_s1) do_s2 <= do_s1;
    end
  end

  assign DO       = do_s2;
  assign rd_valid = valid_s2;
`else
  assign DO       = do_s1;
  assign rd_valid = valid_s1;
`endif

endmodule
